// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned steps_of(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit so the
// caller can form signed overflow.
module serial_adder_digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             ctop_o
);

    logic [DIGIT:0] chain;

    always_comb begin
        chain    = '0;
        sum_o    = '0;
        chain[0] = c_i;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ chain[i];
            chain[i+1]   = (a_i[i] & b_i[i]) | (chain[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = chain[DIGIT];
    assign ctop_o = chain[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: processes DIGIT bits per cycle, LSB digit first, with a
// start/busy/done handshake. Result is held until the next accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned STEPS = steps_of(WIDTH, DIGIT);
    localparam int unsigned CW    = $clog2(STEPS) + 1;

    if (WIDTH % DIGIT != 0) begin : g_width_check
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_cout;
    logic                   dig_ctop;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    serial_adder_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .c_i    (c_q),
        .sum_o  (dig_sum),
        .cout_o (dig_cout),
        .ctop_o (dig_ctop)
    );

    // New digit enters at the MSB end; after STEPS shifts the LSB digit sits at bit 0.
    assign sum_cat = {dig_sum, sum_q};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = left;
                    b_d     = subtract ? ~right : right;
                    c_d     = subtract ? 1'b1 : carry_in;
                    step_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                c_d    = dig_cout;
                sum_d  = sum_cat[WIDTH+DIGIT-1:DIGIT];
                step_d = step_q + CW'(1);
                if (step_q == CW'(STEPS - 1)) begin
                    state_d = StDone;
                    carry_d = dig_cout;
                    ovf_d   = dig_cout ^ dig_ctop;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule
